// File: rtl/codestream_word_merger_pkg.sv
// rtl/codestream_word_merger_pkg.sv - shared widths, merge state and byte-merge helper
package codestream_word_merger_pkg;

  localparam int DATA_W       = 32;
  localparam int BE_W         = 4;
  localparam int ENTRY_META_W = DATA_W + BE_W;

  typedef enum logic {
    MS_EMPTY = 1'b0,
    MS_HOLD  = 1'b1
  } merge_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   mask;
  } merge_payload_t;

  // Overlay the enabled bytes of new_w onto old_w.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        r[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/codestream_word_merger_if.sv
// rtl/codestream_word_merger_if.sv - write stream in, coalesced word stream out
interface codestream_word_merger_if
  import codestream_word_merger_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [BE_W-1:0]       wr_be;

  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_W-1:0]     out_data;
  logic [BE_W-1:0]       out_strb;
  logic                  out_ready;

  modport master (
    input  wr_addr, wr_data, wr_be, out_ready,
    output out_valid, out_addr, out_data, out_strb
  );

  modport slave (
    output wr_addr, wr_data, wr_be, out_ready,
    input  out_valid, out_addr, out_data, out_strb
  );

endinterface

// File: rtl/codestream_word_merger_wfifo.sv
// rtl/codestream_word_merger_wfifo.sv - first-word fall-through word FIFO, push+pop allowed when full
module codestream_word_merger_wfifo #(
  parameter int ENTRY_W    = 68,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [FIFO_AW:0]   level_o
);

  localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               do_push;
  logic               do_pop;

  always_comb begin
    empty_o = (level_q == '0);
    full_o  = (level_q == FULL_LEVEL);
    do_pop  = pop_i & ~empty_o;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    do_push = push_i & (~full_o | do_pop);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + (FIFO_AW+1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/codestream_word_merger.sv
// rtl/codestream_word_merger.sv - coalesces byte-enabled writes per address and queues whole words
module codestream_word_merger
  import codestream_word_merger_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sync_clr_i,
  input  logic                      flush_i,
  codestream_word_merger_if.master  bus,
  output logic [FIFO_AW:0]          fifo_level_o,
  output logic                      overflow_o,
  output logic                      drain_done_o
);

  localparam int ENTRY_W = ADDR_WIDTH + ENTRY_META_W;

  merge_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] h_addr_q, h_addr_d;
  logic [DATA_W-1:0]     h_data_q, h_data_d;
  logic [BE_W-1:0]       h_mask_q, h_mask_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  overflow_q, overflow_d;
  logic                  drain_arm_q, drain_arm_d;

  logic                  write;
  logic                  push;
  logic                  pop;
  logic                  push_drop;
  logic                  drain_cond;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    fifo_head;
  merge_payload_t        head_payload;

  assign write = |bus.wr_be;
  assign pop   = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d      = state_q;
    h_addr_d     = h_addr_q;
    h_data_d     = h_data_q;
    h_mask_d     = h_mask_q;
    flush_pend_d = flush_pend_q;
    push         = 1'b0;
    if (write) begin
      // A flush that coincides with a write is deferred to the next idle cycle.
      if (flush_i) begin
        flush_pend_d = 1'b1;
      end
      if (state_q == MS_HOLD && bus.wr_addr == h_addr_q) begin
        h_data_d = merge_bytes(h_data_q, bus.wr_data, bus.wr_be);
        h_mask_d = h_mask_q | bus.wr_be;
      end else begin
        push     = (state_q == MS_HOLD);
        state_d  = MS_HOLD;
        h_addr_d = bus.wr_addr;
        h_data_d = bus.wr_data;
        h_mask_d = bus.wr_be;
      end
    end else begin
      flush_pend_d = 1'b0;
      if (state_q == MS_HOLD && (h_mask_q == '1 || flush_i || flush_pend_q)) begin
        push     = 1'b1;
        state_d  = MS_EMPTY;
        h_mask_d = '0;
      end
    end
  end

  always_comb begin
    push_drop    = push & fifo_full & ~pop;
    overflow_d   = overflow_q | push_drop;
    drain_cond   = (state_q == MS_EMPTY) & ~flush_pend_q & fifo_empty & ~write;
    drain_done_o = drain_arm_q & drain_cond & ~sync_clr_i;
    // Armed by each flush; a fresh write before the drain completes cancels the pulse.
    drain_arm_d  = drain_arm_q;
    if (flush_i) begin
      drain_arm_d = 1'b1;
    end else if (drain_done_o || write) begin
      drain_arm_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MS_EMPTY;
      h_addr_q     <= '0;
      h_data_q     <= '0;
      h_mask_q     <= '0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
      drain_arm_q  <= 1'b0;
    end else if (sync_clr_i) begin
      state_q      <= MS_EMPTY;
      h_addr_q     <= '0;
      h_data_q     <= '0;
      h_mask_q     <= '0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
      drain_arm_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_addr_q     <= h_addr_d;
      h_data_q     <= h_data_d;
      h_mask_q     <= h_mask_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= overflow_d;
      drain_arm_q  <= drain_arm_d;
    end
  end

  codestream_word_merger_wfifo #(
    .ENTRY_W    (ENTRY_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_wfifo (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (sync_clr_i),
    .push_i      (push),
    .push_data_i ({h_addr_q, h_data_q, h_mask_q}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level_o)
  );

  assign head_payload  = fifo_head[ENTRY_META_W-1:0];
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_addr  = fifo_head[ENTRY_W-1:ENTRY_META_W];
  assign bus.out_data  = head_payload.data;
  assign bus.out_strb  = head_payload.mask;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_codestream_word_merger.sv
// tb/tb_codestream_word_merger.sv - vector table, corner sequences and random run against a queue model
module tb_codestream_word_merger;

  localparam int AW    = 32;
  localparam int DEPTH = 16;
  localparam int FAW   = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        flush;
    logic        ready;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_strb;
    logic [4:0]  e_level;
    logic        e_drain;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } entry_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           sync_clr;
  logic           flush;
  logic [FAW:0]   level;
  logic           overflow;
  logic           drain_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic           m_hold, m_pend, m_arm, m_ovf;
  logic [31:0]    m_haddr, m_hdata;
  logic [3:0]     m_hmask;
  entry_t         mq[$];

  vec_t           vecs[11];

  codestream_word_merger_if #(.ADDR_WIDTH(AW)) bus ();

  codestream_word_merger #(
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (DEPTH),
    .FIFO_AW    (FAW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sync_clr_i   (sync_clr),
    .flush_i      (flush),
    .bus          (bus),
    .fifo_level_o (level),
    .overflow_o   (overflow),
    .drain_done_o (drain_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic fl, input logic rdy);
    bus.wr_addr   = a;
    bus.wr_data   = d;
    bus.wr_be     = be;
    flush         = fl;
    bus.out_ready = rdy;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_head(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
    check({tag, " valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, " addr"},  64'(bus.out_addr),  64'(a));
    check({tag, " data"},  64'(bus.out_data),  64'(d));
    check({tag, " strb"},  64'(bus.out_strb),  64'(s));
  endtask

  // One clock of the reference behaviour: merge register as plain variables, FIFO as a queue.
  task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                            input logic fl, input logic rdy, input logic sc);
    logic   push, pop, fired;
    entry_t pe;
    int     sz;
    if (sc) begin
      m_hold = 1'b0; m_pend = 1'b0; m_arm = 1'b0; m_ovf = 1'b0; m_hmask = 4'h0;
      mq.delete();
      return;
    end
    sz    = mq.size();
    pop   = (sz > 0) && rdy;
    fired = m_arm && !m_hold && !m_pend && sz == 0 && be == 4'h0;
    push  = 1'b0;
    pe    = '{addr: m_haddr, data: m_hdata, strb: m_hmask};
    if (be != 4'h0) begin
      if (fl) m_pend = 1'b1;
      if (m_hold && a == m_haddr) begin
        for (int i = 0; i < 4; i++) if (be[i]) m_hdata[8*i +: 8] = d[8*i +: 8];
        m_hmask = m_hmask | be;
      end else begin
        push    = m_hold;
        m_hold  = 1'b1;
        m_haddr = a;
        m_hdata = d;
        m_hmask = be;
      end
    end else begin
      if (m_hold && (m_hmask == 4'hF || fl || m_pend)) begin
        push   = 1'b1;
        m_hold = 1'b0;
      end
      m_pend = 1'b0;
    end
    if (fl) m_arm = 1'b1;
    else if (fired || be != 4'h0) m_arm = 1'b0;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) mq.push_back(pe);
      else m_ovf = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rd;
    logic [3:0]  rbe;
    logic        rfl, rrdy, rsc, e_drain;
    bit          busy_phase;

    rst = 1'b1;
    sync_clr = 1'b0;
    drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset valid", 64'(bus.out_valid), 64'd0);
    check("reset level", 64'(level), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    check("reset drain", 64'(drain_done), 64'd0);
    check("reset data", 64'(bus.out_data), 64'd0);

    // Rows 0-4: two half-word writes merge into one full word; rows 5-10: flush with drain pulse.
    vecs[0]  = '{32'h100, 32'h0000BBAA, 4'h3, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 5'd0, 1'b0};
    vecs[1]  = '{32'h100, 32'hDDCC0000, 4'hC, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 5'd0, 1'b0};
    vecs[2]  = '{32'h0,   32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 5'd0, 1'b0};
    vecs[3]  = '{32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b1, 32'h100, 32'hDDCCBBAA, 4'hF, 5'd1, 1'b0};
    vecs[4]  = '{32'h0,   32'h0,        4'h0, 1'b0, 1'b1, 1'b1, 32'h100, 32'hDDCCBBAA, 4'hF, 5'd1, 1'b0};
    vecs[5]  = '{32'h10,  32'h00000011, 4'h1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 5'd0, 1'b0};
    vecs[6]  = '{32'h14,  32'h00000022, 4'h1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 5'd0, 1'b0};
    vecs[7]  = '{32'h0,   32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 32'h10,  32'h00000011, 4'h1, 5'd1, 1'b0};
    vecs[8]  = '{32'h0,   32'h0,        4'h0, 1'b0, 1'b1, 1'b1, 32'h14,  32'h00000022, 4'h1, 5'd1, 1'b0};
    vecs[9]  = '{32'h0,   32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 5'd0, 1'b1};
    vecs[10] = '{32'h0,   32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 5'd0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].flush, vecs[i].ready);
      #1;
      check($sformatf("vec%0d valid", i), 64'(bus.out_valid), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d addr", i),  64'(bus.out_addr),  64'(vecs[i].e_addr));
      check($sformatf("vec%0d data", i),  64'(bus.out_data),  64'(vecs[i].e_data));
      check($sformatf("vec%0d strb", i),  64'(bus.out_strb),  64'(vecs[i].e_strb));
      check($sformatf("vec%0d level", i), 64'(level),         64'(vecs[i].e_level));
      check($sformatf("vec%0d drain", i), 64'(drain_done),    64'(vecs[i].e_drain));
      check($sformatf("vec%0d ovf", i),   64'(overflow),      64'd0);
      cyc();
    end

    // Flush coinciding with a partial write: held, then evicted on the next idle cycle only.
    drive(32'h20, 32'h0000AAAA, 4'h3, 1'b1, 1'b0);
    cyc();
    check("t5 held level", 64'(level), 64'd0);
    drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    cyc();
    check("t5 evict level", 64'(level), 64'd1);
    check_head("t5 evict", 32'h20, 32'h0000AAAA, 4'h3);
    drive(32'h30, 32'h00000077, 4'h1, 1'b0, 1'b0);
    cyc();
    drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    cyc();
    check("t5 pend cleared", 64'(level), 64'd1);
    drive(32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    cyc();
    check("t5 flush level", 64'(level), 64'd2);
    drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
    #1;
    check_head("t5 pop0", 32'h20, 32'h0000AAAA, 4'h3);
    cyc();
    check_head("t5 pop1", 32'h30, 32'h00000077, 4'h1);
    check("t5 no early drain", 64'(drain_done), 64'd0);
    cyc();
    check("t5 drain pulse", 64'(drain_done), 64'd1);
    check("t5 drain level", 64'(level), 64'd0);
    cyc();
    check("t5 drain once", 64'(drain_done), 64'd0);

    // 17 full words with the sink stalled: 16 retained, the 17th is dropped.
    for (int k = 0; k < 17; k++) begin
      drive(32'h1000 + 32'(4*k), 32'hA5000000 | 32'(k), 4'hF, 1'b0, 1'b0);
      cyc();
    end
    drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    cyc();
    check("t3 level full", 64'(level), 64'd16);
    check("t3 overflow", 64'(overflow), 64'd1);
    drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      #1;
      check_head($sformatf("t3 word%0d", k), 32'h1000 + 32'(4*k), 32'hA5000000 | 32'(k), 4'hF);
      cyc();
    end
    check("t3 drained", 64'(level), 64'd0);
    check("t3 overflow sticky", 64'(overflow), 64'd1);

    // sync_clr with five queued words and one held word.
    for (int k = 0; k < 6; k++) begin
      drive(32'h2000 + 32'(4*k), 32'h5A000000 | 32'(k), 4'hF, 1'b0, 1'b0);
      cyc();
    end
    check("t6 queued", 64'(level), 64'd5);
    drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    sync_clr = 1'b1;
    cyc();
    sync_clr = 1'b0;
    check("t6 clr valid", 64'(bus.out_valid), 64'd0);
    check("t6 clr level", 64'(level), 64'd0);
    check("t6 clr overflow", 64'(overflow), 64'd0);
    repeat (3) cyc();
    check("t6 no stale valid", 64'(bus.out_valid), 64'd0);
    check("t6 no stale level", 64'(level), 64'd0);

    // Full FIFO with a simultaneous eviction and pop.
    for (int k = 0; k < 17; k++) begin
      drive(32'h3000 + 32'(4*k), 32'hC3000000 | 32'(k), 4'hF, 1'b0, 1'b0);
      cyc();
    end
    check("t4 level full", 64'(level), 64'd16);
    drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
    #1;
    check_head("t4 head0", 32'h3000, 32'hC3000000, 4'hF);
    cyc();
    check("t4 level kept", 64'(level), 64'd16);
    check("t4 no overflow", 64'(overflow), 64'd0);
    for (int k = 1; k < 17; k++) begin
      #1;
      check_head($sformatf("t4 word%0d", k), 32'h3000 + 32'(4*k), 32'hC3000000 | 32'(k), 4'hF);
      cyc();
    end
    check("t4 drained", 64'(level), 64'd0);

    // Asynchronous reset asserted between clock edges.
    for (int k = 0; k < 6; k++) begin
      drive(32'h4000 + 32'(4*k), 32'h3C000000 | 32'(k), 4'hF, 1'b0, 1'b0);
      cyc();
    end
    drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("t6r async valid", 64'(bus.out_valid), 64'd0);
    check("t6r async level", 64'(level), 64'd0);
    cyc();
    rst = 1'b0;
    repeat (2) cyc();
    check("t6r valid", 64'(bus.out_valid), 64'd0);
    check("t6r level", 64'(level), 64'd0);
    check("t6r overflow", 64'(overflow), 64'd0);

    // Random traffic against the queue model.
    m_hold = 1'b0; m_pend = 1'b0; m_arm = 1'b0; m_ovf = 1'b0;
    m_haddr = '0; m_hdata = '0; m_hmask = '0;
    mq.delete();
    busy_phase = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (c % 64 == 0) busy_phase = ($urandom_range(0, 1) == 1);
      ra   = 32'h40 + 32'(4 * $urandom_range(0, 3));
      rd   = $urandom();
      rbe  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      rfl  = ($urandom_range(0, 15) == 0);
      rrdy = busy_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rsc  = ($urandom_range(0, 299) == 0);
      drive(ra, rd, rbe, rfl, rrdy);
      sync_clr = rsc;
      #1;
      e_drain = !rsc && m_arm && !m_hold && !m_pend && mq.size() == 0 && rbe == 4'h0;
      check("rnd valid", 64'(bus.out_valid), 64'(mq.size() != 0));
      check("rnd level", 64'(level), 64'(mq.size()));
      check("rnd overflow", 64'(overflow), 64'(m_ovf));
      check("rnd drain", 64'(drain_done), 64'(e_drain));
      if (mq.size() != 0) begin
        check("rnd addr", 64'(bus.out_addr), 64'(mq[0].addr));
        check("rnd data", 64'(bus.out_data), 64'(mq[0].data));
        check("rnd strb", 64'(bus.out_strb), 64'(mq[0].strb));
      end
      model_step(ra, rd, rbe, rfl, rrdy, rsc);
      cyc();
    end
    sync_clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
